// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO write-side feeder.
package fifo_pkg;

    localparam int STATS_WIDTH = 32;

    // Occupancy needs one extra bit so that "full" is distinguishable from "empty".
    function automatic int occ_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/skid_ring_buffer.sv
// Skid ring storage with read/write pointers and occupancy tracking.
// The caller must not push when full or pop when empty.
module skid_ring_buffer
    import fifo_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int OCC_W = occ_width(DEPTH_LOG2);

    logic [WIDTH-1:0]      r_mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [OCC_W-1:0]      r_occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (push && !pop)
                r_occ <= r_occ + 1'b1;
            else if (pop && !push)
                r_occ <= r_occ - 1'b1;
        end
    end

    // Storage is deliberately not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= push_data;
    end

    // Occupancy never exceeds the depth, so its top bit alone marks "full".
    assign full  = r_occ[DEPTH_LOG2];
    assign empty = (r_occ == '0);
    assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fifo_feed_throttle.sv
// Write-side FIFO feeder: valid/ready upstream, registered write port downstream, skid ring between.
// Optional stall statistics are built when FIFO_FEED_STATS_EN is defined.
module fifo_feed_throttle
    import fifo_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int SKID_DEPTH_LOG2 = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inValid,
    input  logic [WIDTH-1:0]       inData,
    output logic                   inReady,
    input  logic                   almostFull,
    output logic                   writeEnable,
    output logic [WIDTH-1:0]       dataIn,
    output logic                   idle,
    output logic [STATS_WIDTH-1:0] stallCycles
);

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head;
    logic             r_write_enable;
    logic [WIDTH-1:0] r_data_in;

    // Ready comes from registered occupancy only, never from inValid or almostFull.
    assign inReady = !w_full;
    assign w_push  = inValid && !w_full;
    assign w_pop   = !w_empty && !almostFull;

    skid_ring_buffer #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (SKID_DEPTH_LOG2)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (inData),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write_enable <= 1'b0;
            r_data_in      <= '0;
        end else begin
            r_write_enable <= w_pop;
            if (w_pop) r_data_in <= w_head;
        end
    end

    assign writeEnable = r_write_enable;
    assign dataIn      = r_data_in;
    assign idle        = w_empty && !r_write_enable;

`ifdef FIFO_FEED_STATS_EN
    logic [STATS_WIDTH-1:0] r_stall_cycles;
    logic                   w_stall;

    assign w_stall = !w_empty && almostFull;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cycles <= '0;
        else if (w_stall && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + 1'b1;
    end

    assign stallCycles = r_stall_cycles;
`else
    assign stallCycles = '0;
`endif

endmodule
